// File: rtl/hdmi_timing_gen.sv
// Video timing generator for a DVI/HDMI encoder front end: free-running h/v counters,
// a pixel request one cycle ahead of the registered sync/de/data bundle sent to the encoder.
module hdmi_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pix_data,
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_de,
    output logic [23:0] rgb_data,
    output logic        frame_start
);

    localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_VALID + H_FRONT);
    localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_VALID + V_FRONT);
    localparam logic [11:0] H_ACT   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] V_ACT   = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_VALID);
    localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + V_VALID);
    localparam logic [11:0] H_SYNCW = 12'(H_SYNC);
    localparam logic [11:0] V_SYNCW = 12'(V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        rgb_de_q, rgb_de_d;
    logic [23:0] rgb_data_q, rgb_data_d;
    logic        frame_start_q, frame_start_d;

    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        h_act_s;
    logic        v_act_s;
    logic        pix_req_s;

    // Counter next-state: v advances only on the h wrap, so a full frame wrap clears both together.
    always_comb begin
        h_wrap_s = (h_cnt_q == (H_TOTAL - 12'd1));
        v_wrap_s = (v_cnt_q == (V_TOTAL - 12'd1));
        if (h_wrap_s) begin
            h_cnt_d = 12'd0;
            if (v_wrap_s) begin
                v_cnt_d = 12'd0;
            end else begin
                v_cnt_d = v_cnt_q + 12'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
            v_cnt_d = v_cnt_q;
        end
    end

    // Active-window decode and the combinational pixel request/coordinates.
    always_comb begin
        h_act_s   = (h_cnt_q >= H_ACT) && (h_cnt_q < H_END);
        v_act_s   = (v_cnt_q >= V_ACT) && (v_cnt_q < V_END);
        pix_req_s = h_act_s && v_act_s;
        if (pix_req_s) begin
            pix_x = h_cnt_q - H_ACT;
            pix_y = v_cnt_q - V_ACT;
        end else begin
            pix_x = 12'd0;
            pix_y = 12'd0;
        end
    end

    // Encoder-side bundle: every field samples the same counter state, keeping de/c0/c1/data aligned.
    always_comb begin
        hsync_d       = (h_cnt_q < H_SYNCW);
        vsync_d       = (v_cnt_q < V_SYNCW);
        rgb_de_d      = pix_req_s;
        frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        if (pix_req_s) begin
            rgb_data_d = pix_data;
        end else begin
            rgb_data_d = 24'h000000;
        end
    end

    // State registers with synchronous active-low reset; reset abandons the frame in progress.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            rgb_de_q      <= 1'b0;
            rgb_data_q    <= 24'h000000;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_de_q      <= rgb_de_d;
            rgb_data_q    <= rgb_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_req     = pix_req_s;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_de      = rgb_de_q;
    assign rgb_data    = rgb_data_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: default-size and tiny-size instances checked every cycle
// against a closed-form position model (outputs derived from cycles elapsed since reset).
module tb_hdmi_timing_gen;

    localparam int N_CYCLES = 52000;
    localparam longint DEF_RST_POS = 60 * 800 + 500;

    typedef struct packed {
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        fs;
    } pos_t;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst_def_n, rst_sml_n;
    logic [23:0] pd_def, pd_sml;

    logic        req_def, hs_def, vs_def, de_def, fs_def;
    logic [11:0] x_def, y_def;
    logic [23:0] data_def;
    logic        req_sml, hs_sml, vs_sml, de_sml, fs_sml;
    logic [11:0] x_sml, y_sml;
    logic [23:0] data_sml;

    int vectors = 0;
    int miscompares = 0;

    hdmi_timing_gen u_def (
        .sys_clk(sys_clk), .sys_rst_n(rst_def_n), .pix_data(pd_def),
        .pix_req(req_def), .pix_x(x_def), .pix_y(y_def),
        .hsync(hs_def), .vsync(vs_def), .rgb_de(de_def),
        .rgb_data(data_def), .frame_start(fs_def)
    );

    hdmi_timing_gen #(
        .H_SYNC(2), .H_BACK(1), .H_VALID(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1)
    ) u_sml (
        .sys_clk(sys_clk), .sys_rst_n(rst_sml_n), .pix_data(pd_sml),
        .pix_req(req_sml), .pix_x(x_sml), .pix_y(y_sml),
        .hsync(hs_sml), .vsync(vs_sml), .rgb_de(de_sml),
        .rgb_data(data_sml), .frame_start(fs_sml)
    );

    // Position k = clock edges since reset release; counters sit at (k mod Htot, k div Htot mod Vtot).
    function automatic pos_t model_pos(longint k, int hs, int hb, int hv, int hf,
                                       int vs, int vb, int vv, int vf);
        pos_t   p;
        longint ht = hs + hb + hv + hf;
        longint vt = vs + vb + vv + vf;
        longint h  = k % ht;
        longint v  = (k / ht) % vt;
        p.req = (h >= hs + hb) && (h < hs + hb + hv) && (v >= vs + vb) && (v < vs + vb + vv);
        p.x   = p.req ? 12'(h - (hs + hb)) : 12'd0;
        p.y   = p.req ? 12'(v - (vs + vb)) : 12'd0;
        p.hs  = (h < hs);
        p.vs  = (v < vs);
        p.fs  = (h == 0) && (v == 0);
        return p;
    endfunction

    function automatic pos_t pos_def(longint k);
        return model_pos(k, 96, 48, 640, 16, 2, 33, 480, 10);
    endfunction

    function automatic pos_t pos_sml(longint k);
        return model_pos(k, 2, 1, 4, 1, 1, 1, 3, 1);
    endfunction

    function automatic logic [23:0] pattern(pos_t p);
        return {p.y[7:0], p.x[7:0], 8'hA5};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    longint      k_def, k_sml;
    logic [27:0] reg_def, reg_sml;   // {hs, vs, de, data, fs} the DUT must hold after the last edge
    int          def_rst_left, sml_rst_left;
    bit          def_rst_done;
    bit          armed;
    pos_t        c_def, c_sml;

    initial begin
        // Hand-computed anchors for the model itself.
        c_def = pos_def(0);
        check("pin_origin", 64'({c_def.req, c_def.hs, c_def.vs, c_def.fs}), 64'h7);
        c_def = pos_def(35 * 800 + 143);
        check("pin_pre_first_px", 64'(c_def.req), 64'h0);
        c_def = pos_def(35 * 800 + 144);
        check("pin_first_px", 64'({c_def.req, pattern(c_def)}), 64'h10000A5);
        c_def = pos_def((35 + 479) * 800 + 144 + 639);
        check("pin_last_px", 64'({c_def.req, pattern(c_def)}), 64'h1DF7FA5);
        c_def = pos_def(800 * 525);
        check("pin_frame2", 64'({c_def.fs, c_def.hs, c_def.vs}), 64'h7);
        c_sml = pos_sml(47);
        check("pin_sml_wrap_pre", 64'({c_sml.fs, c_sml.hs, c_sml.vs, c_sml.req}), 64'h0);
        c_sml = pos_sml(48);
        check("pin_sml_wrap", 64'({c_sml.fs, c_sml.hs, c_sml.vs}), 64'h7);
        c_sml = pos_sml(19);
        check("pin_sml_first_px", 64'({c_sml.req, c_sml.x, c_sml.y}), 64'h1000000);

        rst_def_n = 1'b0;
        rst_sml_n = 1'b0;
        pd_def = 24'h0;
        pd_sml = 24'h0;
        k_def = 0;
        k_sml = 0;
        reg_def = 28'h0;
        reg_sml = 28'h0;
        def_rst_left = 0;
        sml_rst_left = 0;
        def_rst_done = 1'b0;
        armed = 1'b0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge sys_clk);
            c_def = pos_def(k_def);
            c_sml = pos_sml(k_sml);
            if (armed) begin
                check("default", {11'h0, req_def, x_def, y_def, hs_def, vs_def, de_def, data_def, fs_def},
                      {11'h0, c_def.req, c_def.x, c_def.y, reg_def});
                check("small", {11'h0, req_sml, x_sml, y_sml, hs_sml, vs_sml, de_sml, data_sml, fs_sml},
                      {11'h0, c_sml.req, c_sml.x, c_sml.y, reg_sml});
            end

            // Default instance: initial reset, then one 3-cycle reset at v=60, h=500.
            if (cyc < 3) begin
                rst_def_n = 1'b0;
            end else if (def_rst_left > 0) begin
                rst_def_n = 1'b0;
                def_rst_left--;
            end else if (!def_rst_done && k_def == DEF_RST_POS) begin
                rst_def_n = 1'b0;
                def_rst_left = 2;
                def_rst_done = 1'b1;
            end else begin
                rst_def_n = 1'b1;
            end
            pd_def = c_def.req ? pattern(c_def) : 24'($urandom);

            // Small instance: three clean frames first, then random short resets.
            if (cyc < 3) begin
                rst_sml_n = 1'b0;
            end else if (sml_rst_left > 0) begin
                rst_sml_n = 1'b0;
                sml_rst_left--;
            end else if (cyc > 200 && $urandom_range(0, 39) == 0) begin
                rst_sml_n = 1'b0;
                sml_rst_left = $urandom_range(0, 2);
            end else begin
                rst_sml_n = 1'b1;
            end
            pd_sml = 24'($urandom);

            // Predict the coming edge.
            if (!rst_def_n) begin
                k_def = 0;
                reg_def = 28'h0;
            end else begin
                reg_def = {c_def.hs, c_def.vs, c_def.req, (c_def.req ? pd_def : 24'h0), c_def.fs};
                k_def++;
            end
            if (!rst_sml_n) begin
                k_sml = 0;
                reg_sml = 28'h0;
            end else begin
                reg_sml = {c_sml.hs, c_sml.vs, c_sml.req, (c_sml.req ? pd_sml : 24'h0), c_sml.fs};
                k_sml++;
            end
            armed = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
